// File: rtl/bcd_pair_adder.sv
// Captures two 2-digit BCD operands on strobe rising edges and adds them one digit
// per cycle with decimal correction; the registered sum is held until the next capture.
module bcd_pair_adder #(
  parameter bit ERR_SAT = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       rng_load,
  input  logic [3:0] rng_tens,
  input  logic [3:0] rng_units,
  input  logic       rng2_load,
  input  logic [3:0] rng2_tens,
  input  logic [3:0] rng2_units,
  output logic [3:0] sum_tens,
  output logic [3:0] sum_ones,
  output logic       sum_carry,
  output logic       sum_valid,
  output logic       bcd_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT_B = 3'd1,
    ADD_U  = 3'd2,
    ADD_T  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] a_tens_q, a_tens_d, a_units_q, a_units_d;
  logic [3:0] b_tens_q, b_tens_d, b_units_q, b_units_d;
  logic       hist1_q, hist1_d, hist2_q, hist2_d;
  logic [3:0] units_q, units_d;
  logic       carry_q, carry_d;
  logic [3:0] sum_tens_q, sum_tens_d, sum_ones_q, sum_ones_d;
  logic       sum_carry_q, sum_carry_d, sum_valid_q, sum_valid_d;
  logic       bcd_err_q, bcd_err_d;

  logic       rise1, rise2;
  logic [4:0] u_sum, t_sum;

  function automatic logic [3:0] fix_digit(input logic [3:0] d);
    if (d > 4'd9) return ERR_SAT ? 4'd9 : 4'd0;
    return d;
  endfunction

  assign rise1 = rng_load & ~hist1_q;
  assign rise2 = rng2_load & ~hist2_q;
  assign u_sum = {1'b0, a_units_q} + {1'b0, b_units_q};
  assign t_sum = {1'b0, a_tens_q} + {1'b0, b_tens_q} + {4'b0000, carry_q};

  always_comb begin
    state_d     = state_q;
    a_tens_d    = a_tens_q;
    a_units_d   = a_units_q;
    b_tens_d    = b_tens_q;
    b_units_d   = b_units_q;
    hist1_d     = rng_load;
    hist2_d     = rng2_load;
    units_d     = units_q;
    carry_d     = carry_q;
    sum_tens_d  = sum_tens_q;
    sum_ones_d  = sum_ones_q;
    sum_carry_d = sum_carry_q;
    sum_valid_d = sum_valid_q;
    bcd_err_d   = bcd_err_q;

    case (state_q)
      IDLE, DONE, WAIT_B: begin
        // A recapture in WAIT_B replaces the earlier A; a lone B rise only counts in WAIT_B
        if (rise1) begin
          a_tens_d    = fix_digit(rng_tens);
          a_units_d   = fix_digit(rng_units);
          bcd_err_d   = bcd_err_d | (rng_tens > 4'd9) | (rng_units > 4'd9);
          sum_valid_d = 1'b0;
          state_d     = WAIT_B;
        end
        if (rise2 && (rise1 || state_q == WAIT_B)) begin
          b_tens_d    = fix_digit(rng2_tens);
          b_units_d   = fix_digit(rng2_units);
          bcd_err_d   = bcd_err_d | (rng2_tens > 4'd9) | (rng2_units > 4'd9);
          state_d     = ADD_U;
        end
      end
      ADD_U: begin
        if (u_sum > 5'd9) begin
          units_d = u_sum[3:0] + 4'd6;
          carry_d = 1'b1;
        end else begin
          units_d = u_sum[3:0];
          carry_d = 1'b0;
        end
        state_d = ADD_T;
      end
      ADD_T: begin
        if (t_sum > 5'd9) begin
          sum_tens_d  = t_sum[3:0] + 4'd6;
          sum_carry_d = 1'b1;
        end else begin
          sum_tens_d  = t_sum[3:0];
          sum_carry_d = 1'b0;
        end
        sum_ones_d  = units_q;
        sum_valid_d = 1'b1;
        state_d     = DONE;
      end
      default: begin
        state_d     = IDLE;
        sum_tens_d  = '0;
        sum_ones_d  = '0;
        sum_carry_d = 1'b0;
        sum_valid_d = 1'b0;
      end
    endcase

    if (clear) begin
      state_d     = IDLE;
      a_tens_d    = '0;
      a_units_d   = '0;
      b_tens_d    = '0;
      b_units_d   = '0;
      units_d     = '0;
      carry_d     = 1'b0;
      sum_tens_d  = '0;
      sum_ones_d  = '0;
      sum_carry_d = 1'b0;
      sum_valid_d = 1'b0;
      bcd_err_d   = 1'b0;
    end
  end

  // History resets high so a strobe held through reset is not seen as an edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      a_tens_q    <= '0;
      a_units_q   <= '0;
      b_tens_q    <= '0;
      b_units_q   <= '0;
      hist1_q     <= 1'b1;
      hist2_q     <= 1'b1;
      units_q     <= '0;
      carry_q     <= 1'b0;
      sum_tens_q  <= '0;
      sum_ones_q  <= '0;
      sum_carry_q <= 1'b0;
      sum_valid_q <= 1'b0;
      bcd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_tens_q    <= a_tens_d;
      a_units_q   <= a_units_d;
      b_tens_q    <= b_tens_d;
      b_units_q   <= b_units_d;
      hist1_q     <= hist1_d;
      hist2_q     <= hist2_d;
      units_q     <= units_d;
      carry_q     <= carry_d;
      sum_tens_q  <= sum_tens_d;
      sum_ones_q  <= sum_ones_d;
      sum_carry_q <= sum_carry_d;
      sum_valid_q <= sum_valid_d;
      bcd_err_q   <= bcd_err_d;
    end
  end

  assign sum_tens  = sum_tens_q;
  assign sum_ones  = sum_ones_q;
  assign sum_carry = sum_carry_q;
  assign sum_valid = sum_valid_q;
  assign bcd_err   = bcd_err_q;

endmodule
